output_error_unit: RTL
======================

OUTPUT_ERROR_UNIT -- requirements
Module: output_error_unit

Interface
REQ-001 SHALL have parameter OUTPUT_UNITS, default 2, giving the number of output-layer neurons (minimum 1).
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  prediction/target set offered.
REQ-005 SHALL have port in_ready  output  1  unit can accept a set (high only in IDLE).
REQ-006 SHALL have port predictions  input  sfp[OUTPUT_UNITS]  output-layer activations.
REQ-007 SHALL have port sums  input  sfp[OUTPUT_UNITS]  pre-activation sums; ReLU derivative only.
REQ-008 SHALL have port targets  input  sfp[OUTPUT_UNITS]  desired outputs.
REQ-009 SHALL have port activation  input  act_func  output-layer activation.
REQ-010 SHALL have port out_valid  output  1  gradients and loss are valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port error_gradient  output  sfp[OUTPUT_UNITS]  dLoss/dsum per neuron; feeds the last hidden layer's next-layer gradient input.
REQ-013 SHALL have port loss  output  sfp  half sum of squared errors.

Function
REQ-014 SHALL use a three-state FSM with states IDLE, COMPUTE and DONE.
REQ-015 SHALL accept a set on the cycle in_valid and in_ready are both high, registering predictions, sums, targets and activation, clearing the loss accumulator and index, and entering COMPUTE.
REQ-016 SHALL process one neuron per COMPUTE cycle at index i = 0..OUTPUT_UNITS-1, so that only one derivative multiplier and one gradient multiplier are needed.
REQ-017 SHALL compute diff = sfp_sub(pred[i], target[i]).
REQ-018 SHALL select the derivative d by activation: Sigmoid gives p*(ONE-p); Tanh gives ONE-p*p; ReLU gives ONE if sums[i] >= 0, else 0; any other value gives ONE.
REQ-019 SHALL register error_gradient[i] = sfp_mul(diff, d) and accumulate acc = sfp_add(acc, sfp_mul(diff, diff)).
REQ-020 SHALL enter DONE after index OUTPUT_UNITS-1, drive loss = acc >>> 1 and assert out_valid.
REQ-021 SHALL hold out_valid, error_gradient and loss stable in DONE until out_ready is high, then return to IDLE on the next edge.
REQ-022 SHALL give a latency of OUTPUT_UNITS+1 cycles from the accept edge to out_valid, and accept at most one set every OUTPUT_UNITS+2 cycles.
REQ-023 SHALL ignore in_valid outside IDLE, and input changes after the accept edge SHALL NOT affect the result.
REQ-024 SHALL hold error_gradient and loss at their last values in IDLE; neither is valid unless out_valid is high.
REQ-025 SHALL perform all arithmetic with FixedPoint package functions, with no widened intermediate formats.
REQ-026 SHALL size the index counter as $clog2(OUTPUT_UNITS+1) bits and never index past OUTPUT_UNITS-1.

Reset
REQ-027 SHALL on rst, in any state, enter IDLE, clear out_valid, all error_gradient entries, loss, acc and index, and set in_ready to 1 on the following cycle.
REQ-028 SHALL give rst priority over any in_valid/out_ready handshake in the same cycle.

Structure
REQ-029 SHALL take sfp, ONE, HALF and the sfp_* functions from FixedPoint, and act_func from Common.
REQ-030 SHALL define the FSM state enum locally.
REQ-031 SHALL place the derivative selection in a combinational sub-module named act_derivative, reusable by Perceptron in a later revision.

Verification
REQ-032 SHALL cover: Sigmoid, N=1, pred 0.75, target 1.0 -> grad -0.046875, loss 0.03125, out_valid 2 cycles after accept.
REQ-033 SHALL cover: Tanh, N=2, pred {0.5, -0.5}, target {0, 0} -> grads {0.375, -0.375}, loss 0.25.
REQ-034 SHALL cover: ReLU, sums {-1.0, 2.0}, pred {0, 2.0}, target {1.0, 1.0} -> grads {0, 1.0}, loss 1.0.
REQ-035 SHALL cover: out_ready low for 5 cycles in DONE -> outputs stable, in_ready low and a second in_valid ignored; it SHALL be accepted only once the unit is back in IDLE.
REQ-036 SHALL cover: rst asserted on the second COMPUTE cycle -> next cycle IDLE, out_valid 0, grads and loss 0, in_ready 1.
REQ-037 SHALL cover: inputs changed on the cycle after accept -> result matches the originally captured values.

Source files
------------

// File: rtl/Common.sv
// Types shared across the network blocks.
package Common;

   typedef enum logic [1:0] {
      ACT_NONE,
      ACT_SIGMOID,
      ACT_TANH,
      ACT_RELU
   } act_func;

endpackage

// File: rtl/FixedPoint.sv
// Signed Q8.8 fixed-point type and saturating arithmetic
// shared by the neural-network datapath blocks.
package FixedPoint;

   localparam int SFP_W = 16;
   localparam int SFP_F = 8;

   typedef logic signed [SFP_W-1:0] sfp;
   typedef logic signed [2*SFP_W-1:0] sfp_wide_t;

   localparam sfp ONE     = sfp'(1 << SFP_F);
   localparam sfp HALF    = sfp'(1 << (SFP_F - 1));
   localparam sfp SFP_MAX = {1'b0, {(SFP_W-1){1'b1}}};
   localparam sfp SFP_MIN = {1'b1, {(SFP_W-1){1'b0}}};

   function automatic sfp sfp_sat(sfp_wide_t v);
      if (v > sfp_wide_t'(SFP_MAX)) return SFP_MAX;
      if (v < sfp_wide_t'(SFP_MIN)) return SFP_MIN;
      return v[SFP_W-1:0];
   endfunction

   function automatic sfp sfp_add(sfp a, sfp b);
      return sfp_sat(sfp_wide_t'(a) + sfp_wide_t'(b));
   endfunction

   function automatic sfp sfp_sub(sfp a, sfp b);
      return sfp_sat(sfp_wide_t'(a) - sfp_wide_t'(b));
   endfunction

   // Floor rounding: the arithmetic shift truncates toward -inf.
   function automatic sfp sfp_mul(sfp a, sfp b);
      sfp_wide_t p;
      p = sfp_wide_t'(a) * sfp_wide_t'(b);
      return sfp_sat(p >>> SFP_F);
   endfunction

endpackage

// File: rtl/output_error_unit_pkg.sv
// Helpers local to the output error unit.
package output_error_unit_pkg;

   import FixedPoint::*;

   function automatic int idx_width(int units);
      return $clog2(units + 1);
   endfunction

   function automatic sfp half_sse(sfp acc);
      return acc >>> 1;
   endfunction

endpackage

// File: rtl/output_error_unit_if.sv
// Handshake and data bundle between the output layer,
// the output error unit and the backprop consumer.
interface output_error_unit_if #(
   parameter int OUTPUT_UNITS = 2
) ();

   import FixedPoint::*;
   import Common::*;

   logic                     in_valid;
   logic                     in_ready;
   sfp [OUTPUT_UNITS-1:0]    predictions;
   sfp [OUTPUT_UNITS-1:0]    sums;
   sfp [OUTPUT_UNITS-1:0]    targets;
   act_func                  activation;
   logic                     out_valid;
   logic                     out_ready;
   sfp [OUTPUT_UNITS-1:0]    error_gradient;
   sfp                       loss;

   modport master (
      output in_valid,
      input  in_ready,
      output predictions,
      output sums,
      output targets,
      output activation,
      input  out_valid,
      output out_ready,
      input  error_gradient,
      input  loss
   );

   modport slave (
      input  in_valid,
      output in_ready,
      input  predictions,
      input  sums,
      input  targets,
      input  activation,
      output out_valid,
      input  out_ready,
      output error_gradient,
      output loss
   );

endinterface

// File: rtl/act_derivative.sv
// Activation derivative expressed in terms of the activation output
// (ReLU uses the pre-activation sum); one shared multiplier.
module act_derivative
   import FixedPoint::*;
   import Common::*;
(
   input  act_func act_i,
   input  sfp      pred_i,
   input  sfp      sum_i,
   output sfp      deriv_o
);

   sfp opnd;
   sfp prod;

   always_comb begin
      opnd = pred_i;
      if (act_i == ACT_SIGMOID) opnd = sfp_sub(ONE, pred_i);
      prod = sfp_mul(pred_i, opnd);
      deriv_o = ONE;
      unique case (1'b1)
         (act_i == ACT_SIGMOID): deriv_o = prod;
         (act_i == ACT_TANH):    deriv_o = sfp_sub(ONE, prod);
         (act_i == ACT_RELU):    deriv_o = (sum_i >= sfp'(0)) ? ONE : '0;
         default:                deriv_o = ONE;
      endcase
   end

endmodule

// File: rtl/output_error_unit.sv
// Output-layer error unit: per-neuron dLoss/dsum and half-SSE loss,
// one neuron per cycle through a shared datapath.
module output_error_unit
   import FixedPoint::*;
   import Common::*;
   import output_error_unit_pkg::*;
#(
   parameter int OUTPUT_UNITS = 2
) (
   input logic               clk,
   input logic               rst,
   output_error_unit_if.slave bus
);

   localparam int IW = idx_width(OUTPUT_UNITS);

   typedef enum logic [1:0] {
      IDLE,
      COMPUTE,
      DONE
   } state_e;

   state_e                state_q, state_d;
   logic [IW-1:0]         idx_q, idx_d;
   sfp [OUTPUT_UNITS-1:0] pred_q, pred_d;
   sfp [OUTPUT_UNITS-1:0] sum_q, sum_d;
   sfp [OUTPUT_UNITS-1:0] tgt_q, tgt_d;
   sfp [OUTPUT_UNITS-1:0] grad_q, grad_d;
   act_func               act_q, act_d;
   sfp                    acc_q, acc_d;
   sfp                    loss_q, loss_d;

   sfp cur_p, cur_s, cur_t;
   sfp deriv, diff, sq, gmul;
   logic last;

   // Select the current neuron without indexing past the array.
   always_comb begin
      cur_p = '0;
      cur_s = '0;
      cur_t = '0;
      for (int i = 0; i < OUTPUT_UNITS; i++) begin
         if (idx_q == IW'(i)) begin
            cur_p = pred_q[i];
            cur_s = sum_q[i];
            cur_t = tgt_q[i];
         end
      end
   end

   act_derivative u_deriv (
      .act_i   (act_q),
      .pred_i  (cur_p),
      .sum_i   (cur_s),
      .deriv_o (deriv)
   );

   assign diff = sfp_sub(cur_p, cur_t);
   assign sq   = sfp_mul(diff, diff);
   assign gmul = sfp_mul(diff, deriv);
   assign last = (idx_q == IW'(OUTPUT_UNITS - 1));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pred_d  = pred_q;
      sum_d   = sum_q;
      tgt_d   = tgt_q;
      act_d   = act_q;
      acc_d   = acc_q;
      grad_d  = grad_q;
      loss_d  = loss_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               pred_d  = bus.predictions;
               sum_d   = bus.sums;
               tgt_d   = bus.targets;
               act_d   = bus.activation;
               acc_d   = '0;
               idx_d   = '0;
               state_d = COMPUTE;
            end
         end
         COMPUTE: begin
            acc_d = sfp_add(acc_q, sq);
            for (int i = 0; i < OUTPUT_UNITS; i++) begin
               if (idx_q == IW'(i)) grad_d[i] = gmul;
            end
            if (last) begin
               loss_d  = half_sse(acc_d);
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         pred_q  <= '0;
         sum_q   <= '0;
         tgt_q   <= '0;
         act_q   <= ACT_NONE;
         acc_q   <= '0;
         grad_q  <= '0;
         loss_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pred_q  <= pred_d;
         sum_q   <= sum_d;
         tgt_q   <= tgt_d;
         act_q   <= act_d;
         acc_q   <= acc_d;
         grad_q  <= grad_d;
         loss_q  <= loss_d;
      end
   end

   assign bus.in_ready       = (state_q == IDLE);
   assign bus.out_valid      = (state_q == DONE);
   assign bus.error_gradient = grad_q;
   assign bus.loss           = loss_q;

endmodule
